// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer.
//   fetch_state_t : sequencer state encoding (exported on the debug port)
//   SEL_*         : next-PC mux select values
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        STALL = 3'd4
    } fetch_state_t;

    // ctrlMux1: PC+4 vs branch target; ctrlMux2: writeback PC (overrides mux1)
    localparam logic SEL_PC4    = 1'b0;
    localparam logic SEL_BRANCH = 1'b1;
    localparam logic SEL_WB     = 1'b1;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: drives the PC enable, the fetch/decode pipe
// enable/clear and the next-PC mux selects around a variable-latency
// instruction memory with a req/ack handshake (one access outstanding).
//
// Ports
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   imemAck        : in,  instruction for the outstanding access valid
//   stallD         : in,  decode stall request
//   branchTakenE   : in,  taken branch resolved in execute
//   pcWriteW       : in,  PC written by writeback
//   imemReq        : out, one-cycle access start pulse
//   pcEnable       : out, PC register load enable
//   pipeEnable     : out, fetch/decode register enable
//   clearPipe      : out, fetch/decode register clear (with pipeEnable)
//   ctrlMux1       : out, 1 = branch target, 0 = PC+4
//   ctrlMux2       : out, 1 = writeback PC (overrides mux1)
//   timeout        : out, sticky: an access waited more than MAX_WAIT cycles
//   state          : out, current state (debug)
module fetch_sequencer
    import fetch_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_WAIT    = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       imemAck,
    input  logic       stallD,
    input  logic       branchTakenE,
    input  logic       pcWriteW,
    output logic       imemReq,
    output logic       pcEnable,
    output logic       pipeEnable,
    output logic       clearPipe,
    output logic       ctrlMux1,
    output logic       ctrlMux2,
    output logic       timeout,
    output logic [2:0] state
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    fetch_state_t cur, nxt;
    logic [BW-1:0] bootCnt;
    logic [WW-1:0] waitCnt;
    logic          redirect;

    assign redirect = branchTakenE | pcWriteW;
    assign state    = cur;

    always_ff @(posedge clock) begin
        if (reset) begin
            cur     <= BOOT;
            bootCnt <= BW'(BOOT_CYCLES - 1);
            waitCnt <= '0;
            timeout <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == BOOT && bootCnt != '0)
                bootCnt <= bootCnt - 1'b1;
            if (cur == ISSUE)
                waitCnt <= '0;
            // Only a genuine wait (no ack, no flush) ages the access.
            if (cur == WAIT && !redirect && !imemAck) begin
                if (waitCnt == WW'(MAX_WAIT))
                    timeout <= 1'b1;
                else
                    waitCnt <= waitCnt + 1'b1;
            end
        end
    end

    always_comb begin
        nxt        = cur;
        imemReq    = 1'b0;
        pcEnable   = 1'b0;
        pipeEnable = 1'b0;
        clearPipe  = 1'b0;
        ctrlMux1   = SEL_PC4;
        ctrlMux2   = 1'b0;

        if (reset || cur == BOOT) begin
            // Flush the pipe; acks and redirects are ignored here.
            pipeEnable = 1'b1;
            clearPipe  = 1'b1;
            if (!reset && bootCnt == '0)
                nxt = ISSUE;
        end else if (redirect) begin
            pcEnable   = 1'b1;
            pipeEnable = 1'b1;
            clearPipe  = 1'b1;
            ctrlMux2   = pcWriteW ? SEL_WB : 1'b0;
            ctrlMux1   = (branchTakenE && !pcWriteW) ? SEL_BRANCH : SEL_PC4;
            // An ISSUE still launches its access; its data gets dropped in DRAIN.
            imemReq    = (cur == ISSUE);
            if (cur == ISSUE || ((cur == WAIT || cur == DRAIN) && !imemAck))
                nxt = DRAIN;
            else
                nxt = ISSUE;
        end else begin
            case (cur)
                ISSUE: begin
                    imemReq    = 1'b1;
                    pipeEnable = !stallD;
                    clearPipe  = !stallD;
                    nxt        = WAIT;
                end
                WAIT: begin
                    if (imemAck && !stallD) begin
                        pcEnable   = 1'b1;
                        pipeEnable = 1'b1;
                        nxt        = ISSUE;
                    end else if (imemAck) begin
                        // Dropped; PC is untouched so the same address is refetched.
                        nxt = STALL;
                    end else begin
                        pipeEnable = !stallD;
                        clearPipe  = !stallD;
                    end
                end
                DRAIN: begin
                    pipeEnable = !stallD;
                    clearPipe  = !stallD;
                    if (imemAck)
                        nxt = ISSUE;
                end
                STALL: begin
                    if (!stallD)
                        nxt = ISSUE;
                end
                default: nxt = BOOT;
            endcase
        end
    end

endmodule
